operand_fwd_stage: RTL

Parametrised successor of the operand forwarding mux. Sits at the ID/EX boundary of the pipelined core. For each of NUM_OPS source operands it selects between register-file data, the EX/MEM result and the MEM/WB result. It detects load-use hazards and registers the chosen operands into the ID/EX pipeline register, with stall and flush control and a saturating hazard counter.

---
 rtl/operand_fwd_stage_pkg.sv | 16 +
 rtl/operand_fwd_stage_fwd_select.sv | 57 +++++
 rtl/operand_fwd_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/operand_fwd_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_stage_pkg
// Description : Shared forwarding select encodings for the ID/EX operand
//               forwarding stage.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_fwd_stage_pkg;

    // Per-operand source select codes, also exported on fwd_sel_o
    localparam logic [1:0] FWD_RF  = 2'b00;  // register-file read data
    localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB write-back data
    localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

endpackage
`default_nettype wire

// File: rtl/operand_fwd_stage_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Combinational compare-and-mux for one source operand. Picks
//               register-file, EX/MEM or MEM/WB data and flags a load-use hit.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
    import operand_fwd_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_exmem_we,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_data,
    input  logic              i_exmem_is_load,
    input  logic              i_memwb_we,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_data,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_sel,
    output logic              o_load_hit
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = i_exmem_we && (i_exmem_rd == i_addr);
    assign w_memwb_hit = i_memwb_we && (i_memwb_rd == i_addr);

    // Priority select: r0 never forwards, EX/MEM (younger) beats MEM/WB
    always_comb begin
        o_data     = i_rf_data;
        o_sel      = FWD_RF;
        o_load_hit = 1'b0;
        if (i_addr != '0) begin
            if (w_exmem_hit) begin
                // A load in EX/MEM has no data yet; MEM/WB must not be used
                // because it would supply a stale, older value.
                if (i_exmem_is_load) begin
                    o_load_hit = 1'b1;
                end else begin
                    o_data = i_exmem_data;
                    o_sel  = FWD_MEM;
                end
            end else if (w_memwb_hit) begin
                o_data = i_memwb_data;
                o_sel  = FWD_WB;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_stage
// Description : ID/EX operand forwarding stage. Selects each source operand
//               from RF / EX/MEM / MEM/WB, raises load-use stalls, registers
//               the operands with stall/flush control and counts hazard
//               stall cycles with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fwd_stage
    import operand_fwd_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_OPS = 2,
    parameter int CNT_W   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  logic [NUM_OPS*REG_AW-1:0]   rs_addr_i,
    input  logic [NUM_OPS*DATA_W-1:0]   rs_data_i,
    input  logic                        exmem_we_i,
    input  logic [REG_AW-1:0]           exmem_rd_i,
    input  logic [DATA_W-1:0]           exmem_data_i,
    input  logic                        exmem_is_load_i,
    input  logic                        memwb_we_i,
    input  logic [REG_AW-1:0]           memwb_rd_i,
    input  logic [DATA_W-1:0]           memwb_data_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    output logic                        valid_o,
    output logic [NUM_OPS*DATA_W-1:0]   op_data_o,
    output logic [NUM_OPS*2-1:0]        fwd_sel_o,
    output logic                        hazard_stall_o,
    output logic [CNT_W-1:0]            hazard_cnt_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_OPS*DATA_W-1:0] w_sel_data;
    logic [NUM_OPS*2-1:0]      w_sel_code;
    logic [NUM_OPS-1:0]        w_load_hit;

    logic                      r_valid;
    logic [NUM_OPS*DATA_W-1:0] r_op_data;
    logic [NUM_OPS*2-1:0]      r_fwd_sel;
    logic [CNT_W-1:0]          r_hazard_cnt;

    generate
        for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
            fwd_select #(
                .DATA_W (DATA_W),
                .REG_AW (REG_AW)
            ) u_fwd_select (
                .i_addr          (rs_addr_i[k*REG_AW +: REG_AW]),
                .i_rf_data       (rs_data_i[k*DATA_W +: DATA_W]),
                .i_exmem_we      (exmem_we_i),
                .i_exmem_rd      (exmem_rd_i),
                .i_exmem_data    (exmem_data_i),
                .i_exmem_is_load (exmem_is_load_i),
                .i_memwb_we      (memwb_we_i),
                .i_memwb_rd      (memwb_rd_i),
                .i_memwb_data    (memwb_data_i),
                .o_data          (w_sel_data[k*DATA_W +: DATA_W]),
                .o_sel           (w_sel_code[k*2 +: 2]),
                .o_load_hit      (w_load_hit[k])
            );
        end
    endgenerate

    // Zero-latency stall request: any operand waiting on an in-flight load
    assign hazard_stall_o = valid_i && !flush_i && (|w_load_hit);

    // ID/EX pipeline register: flush > stall > hazard bubble > capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid   <= 1'b0;
            r_op_data <= '0;
            r_fwd_sel <= '0;
        end else if (flush_i) begin
            r_valid   <= 1'b0;
            r_op_data <= '0;
            r_fwd_sel <= {NUM_OPS{FWD_RF}};
        end else if (stall_i) begin
            r_valid   <= r_valid;
        end else if (hazard_stall_o) begin
            // Bubble; the instruction stays upstream and retries next cycle
            r_valid   <= 1'b0;
        end else begin
            r_valid   <= valid_i;
            r_op_data <= w_sel_data;
            r_fwd_sel <= w_sel_code;
        end
    end

    // Saturating count of hazard cycles that actually inserted a bubble
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hazard_cnt <= '0;
        end else if (hazard_stall_o && !stall_i && (r_hazard_cnt != c_cnt_max)) begin
            r_hazard_cnt <= r_hazard_cnt + c_cnt_one;
        end
    end

    assign valid_o      = r_valid;
    assign op_data_o    = r_op_data;
    assign fwd_sel_o    = r_fwd_sel;
    assign hazard_cnt_o = r_hazard_cnt;

endmodule
`default_nettype wire
